pu_riscv_ex_sched: RTL
======================

# pu_riscv_ex_sched

Execute-stage scheduler for the PU-RISCV core. It sits beside the single-cycle ALU and shares the execute slot between three units: the ALU, a fixed-latency multiplier and a variable-latency divider. It decodes the ID-stage instruction class, launches the long-latency units, and drives `ex_stall` to freeze the ALU and ID stage. It also merges all results into a single writeback stream with bubble marking.

## Interface
- `XLEN`, 64, datapath width
- `ILEN`, 64, instruction width
- `MUL_LAT`, 3, multiplier latency in cycles, legal range 1..7

- `clk`  in  1  clock
- `rstn`  in  1  asynchronous active-low reset
- `id_bubble`  in  1  ID instruction is a bubble
- `id_instr`  in  ILEN  ID instruction
- `ex_flush`  in  1  synchronous kill of the execute slot
- `wb_stall`  in  1  writeback cannot accept this cycle
- `alu_bubble`  in  1  registered ALU bubble
- `alu_r`  in  XLEN  registered ALU result
- `mul_start`  out  1  one-cycle multiplier launch
- `mul_op`  out  3  {word, func3[1:0]}, valid with `mul_start`
- `mul_r`  in  XLEN  multiplier result, valid exactly MUL_LAT cycles after `mul_start`
- `div_ready`  in  1  divider idle
- `div_start`  out  1  one-cycle divider launch
- `div_op`  out  3  {word, func3[1:0]}, valid with `div_start`
- `div_done`  in  1  one-cycle divider completion pulse
- `div_r`  in  XLEN  divider result, valid with `div_done`
- `div_kill`  out  1  abort the in-flight division
- `ex_stall`  out  1  freeze the ALU and ID stage
- `ex_bubble`  out  1  writeback entry is a bubble
- `ex_r`  out  XLEN  writeback result

## Operation
- **Class decode** uses opcode `id_instr[6:2]`.
  - MUL class: opcode 5'b01100 or 5'b01110, func7 7'b0000001, func3[2]=0.
  - DIV class: the same opcode and func7 match, with func3[2]=1.
  - ALU class: everything else.
  - `word` is 1 for opcode 5'b01110.
  - A class is ignored when `id_bubble`=1.
- **Operands:** units take `opA`/`opB` directly from the ID stage. Operands stay stable because ID is frozen while the scheduler is not IDLE.
- **State machine:** states are IDLE, MUL_WAIT, DIV_PEND, DIV_WAIT, DONE.
- **IDLE**
  - Output path: `ex_r`=`alu_r`, `ex_bubble`=`alu_bubble`.
  - ALU class: `ex_stall`=`wb_stall`.
  - MUL class, `wb_stall`=1: hold in IDLE with `ex_stall`=1; the ALU result stays visible and is not duplicated.
  - MUL class, `wb_stall`=0: pulse `mul_start`, load `cnt`=MUL_LAT-1, go to MUL_WAIT, `ex_stall`=1. The previous ALU result is consumed this cycle.
  - DIV class, `wb_stall`=0: go to DIV_PEND, `ex_stall`=1.
- **MUL_WAIT:** `ex_bubble`=1 and `ex_stall`=1. Decrement `cnt`. When `cnt`=0, capture `mul_r` into `res_q` and go to DONE.
- **DIV_PEND:** `ex_bubble`=1 and `ex_stall`=1. `div_start`=`div_ready`; if `div_ready`=1, go to DIV_WAIT.
- **DIV_WAIT:** `ex_bubble`=1 and `ex_stall`=1. On `div_done`, capture `div_r` into `res_q` and go to DONE. `div_done` is ignored in every other state.
- **DONE**
  - `ex_r`=`res_q`, `ex_bubble`=0, `ex_stall`=`wb_stall`.
  - If `wb_stall`=0, go to IDLE. The ALU then latches the MUL/DIV instruction, which it reports as a bubble, so no duplicate writeback occurs.
- **Flush:** `ex_flush`=1 in any state forces next state IDLE and forces `ex_bubble`=1 this cycle. It suppresses `mul_start` and `div_start`, and drops `res_q` validity.
  - `div_kill` = `ex_flush` & (state==DIV_WAIT).
  - A multiplier result already in flight is discarded; the counter is cleared.
- **Simultaneous events:** `ex_flush` has priority over `div_done`, the `cnt`=0 capture, and issue.

## Timing
- **Reset values:** state IDLE, `cnt`=0, `res_q`=0. `mul_start`, `div_start` and `div_kill` are 0. `ex_stall`=`wb_stall`. `ex_bubble` follows `alu_bubble`, which is 1 in reset.
- **Reset mid-operation:** returns to IDLE with no pending result and no start pulse.
- **MUL latency:** issue at cycle T gives `mul_start`@T, capture@T+MUL_LAT, result visible@T+MUL_LAT+1.
- **DIV latency:** result visible one cycle after `div_done`.
- All start/kill outputs are single-cycle and combinational from state and inputs. `mul_op`/`div_op` are combinational from `id_instr`.
- Back-to-back MUL: the second MUL is issued in the IDLE cycle that follows DONE, at the earliest.
- `wb_stall` asserted in DONE holds `ex_r`/`ex_bubble` stable until accepted.

## Test plan
- **ALU stream:** ADD then XORI with `wb_stall`=0 -> `ex_stall` stays 0; `ex_r` equals `alu_r` each cycle; no start pulses.
- **MUL, MUL_LAT=3:** issue@T with `mul_r`=0x1234 driven at T+3 -> `mul_start`@T; `ex_bubble`=1 for T+1..T+3; `ex_r`=0x1234 with `ex_bubble`=0 @T+4; `ex_stall`=0 @T+4.
- **DIV with busy divider:** `div_ready`=0 for 2 cycles, `div_done` 5 cycles after start, `div_r`=0x7 -> `div_start` once when ready rises; `ex_r`=0x7 one cycle after `div_done`; no duplicate ALU writeback.
- **Backpressure in DONE:** `wb_stall`=1 for 3 cycles -> `ex_r`/`ex_bubble` held stable, `ex_stall`=1; single acceptance when `wb_stall` drops.
- **Flush in DIV_WAIT:** assert `ex_flush` 2 cycles after `div_start` -> `div_kill`=1 that cycle; state IDLE; a later `div_done` is ignored; no result is written back.
- **Reset mid-MUL:** deassert `rstn` in MUL_WAIT -> state IDLE and `ex_stall`=`wb_stall` immediately; no result after reset release.

Source files
------------

// File: rtl/pu_riscv_ex_sched.sv
// Execute-stage scheduler: shares the EX slot between the single-cycle ALU,
// a fixed-latency multiplier and a variable-latency divider, freezes ID/ALU
// while a long-latency op is outstanding, and merges results into one
// writeback stream with bubble marking.
module pu_riscv_ex_sched #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 64,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_bubble,
  input  logic [ILEN-1:0] id_instr,
  input  logic            ex_flush,
  input  logic            wb_stall,
  input  logic            alu_bubble,
  input  logic [XLEN-1:0] alu_r,
  output logic            mul_start,
  output logic [2:0]      mul_op,
  input  logic [XLEN-1:0] mul_r,
  input  logic            div_ready,
  output logic            div_start,
  output logic [2:0]      div_op,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_r,
  output logic            div_kill,
  output logic            ex_stall,
  output logic            ex_bubble,
  output logic [XLEN-1:0] ex_r
);

  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_PEND, DIV_WAIT, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

  state_t          state;
  logic [2:0]      cnt;
  logic [XLEN-1:0] res_q;

  // Class decode of the ID-stage instruction
  logic [4:0] opc;
  logic [6:0] func7;
  logic [2:0] func3;
  logic       word, is_md, is_mul, is_div;

  assign opc    = id_instr[6:2];
  assign func7  = id_instr[31:25];
  assign func3  = id_instr[14:12];
  assign word   = (opc == 5'b01110);
  assign is_md  = ~id_bubble && (opc == 5'b01100 || opc == 5'b01110) && (func7 == 7'b0000001);
  assign is_mul = is_md & ~func3[2];
  assign is_div = is_md &  func3[2];
  assign mul_op = {word, func3[1:0]};
  assign div_op = {word, func3[1:0]};

  // Register/operand fields are consumed by the units directly, not here
  logic unused_instr;
  assign unused_instr = ^{id_instr[ILEN-1:32], id_instr[24:15], id_instr[11:7], id_instr[1:0]};

  // Output path, stall and launch pulses: combinational from state and inputs
  always_comb begin
    mul_start = 1'b0;
    div_start = 1'b0;
    div_kill  = 1'b0;
    ex_r      = alu_r;
    ex_bubble = alu_bubble;
    ex_stall  = wb_stall;
    case (state)
      IDLE: begin
        // Hold ID while a long op waits for writeback to free up
        if (is_mul | is_div) begin
          ex_stall  = 1'b1;
          mul_start = is_mul & ~wb_stall;
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        ex_bubble = 1'b1;
        ex_stall  = 1'b1;
      end
      DIV_PEND: begin
        ex_bubble = 1'b1;
        ex_stall  = 1'b1;
        div_start = div_ready;
      end
      DONE: begin
        ex_r      = res_q;
        ex_bubble = 1'b0;
      end
      default: ;
    endcase
    if (ex_flush) begin
      ex_bubble = 1'b1;
      mul_start = 1'b0;
      div_start = 1'b0;
      div_kill  = (state == DIV_WAIT);
    end
  end

  // Scheduler state, multiplier countdown and captured long-op result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      res_q <= '0;
    end else if (ex_flush) begin
      // Flush wins over issue, capture and completion; in-flight mul is dropped
      state <= IDLE;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul & ~wb_stall) begin
            state <= MUL_WAIT;
            cnt   <= CNT_INIT;
          end else if (is_div & ~wb_stall) begin
            state <= DIV_PEND;
          end
        end
        MUL_WAIT: begin
          if (cnt == 3'd0) begin
            res_q <= mul_r;
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DIV_PEND: if (div_ready) state <= DIV_WAIT;
        DIV_WAIT: begin
          if (div_done) begin
            res_q <= div_r;
            state <= DONE;
          end
        end
        DONE:     if (!wb_stall) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
